// File: rtl/dense_layer_seq.sv
// Sequential dense (fully connected) layer: streams x one element per beat,
// accumulates all neurons in parallel, then emits biased/shifted/saturated results.
module dense_layer_seq #(
    parameter int DATA_W    = 32,
    parameter int IN_DIM    = 64,
    parameter int OUT_DIM   = 8,
    parameter int FRAC_BITS = 0,
    parameter int RELU_EN   = 0,
    localparam int ADDR_W   = (OUT_DIM * IN_DIM > 1) ? $clog2(OUT_DIM * IN_DIM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy
);
    localparam int ACC_W  = 2 * DATA_W + $clog2(IN_DIM);
    localparam int SUM_W  = ACC_W + 1;
    localparam int IDX_W  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int OIDX_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_OUTPUT} state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DATA_W-1:0] r_w   [OUT_DIM*IN_DIM];
    logic signed [DATA_W-1:0] r_b   [OUT_DIM];
    logic signed [ACC_W-1:0]  r_acc [OUT_DIM];
    logic signed [DATA_W-1:0] r_res [OUT_DIM];
    logic [IDX_W-1:0]         r_idx;
    logic [OIDX_W-1:0]        r_oidx;

    logic                       w_accept;
    logic                       w_last_beat;
    logic                       w_last_out;
    logic [IDX_W-1:0]           w_idx_sel;
    logic signed [2*DATA_W-1:0] w_full [OUT_DIM];
    logic signed [ACC_W-1:0]    w_prod [OUT_DIM];
    logic signed [SUM_W-1:0]    w_sum  [OUT_DIM];
    logic signed [DATA_W-1:0]   w_res  [OUT_DIM];

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_idx == IDX_W'(IN_DIM - 1));
    assign w_last_out  = (r_oidx == OIDX_W'(OUT_DIM - 1));
    // The first beat always uses weight column 0, whatever idx holds.
    assign w_idx_sel   = (r_state == S_IDLE) ? '0 : r_idx;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = (IN_DIM == 1) ? S_FINAL : S_ACCUM;
            S_ACCUM:  if (w_accept && w_last_beat) w_next = S_FINAL;
            S_FINAL:  w_next = S_OUTPUT;
            S_OUTPUT: if (out_ready && w_last_out) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (r_state)
            S_IDLE:   in_ready = 1'b1;
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_FINAL:  busy = 1'b1;
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_res[r_oidx];
                out_last  = w_last_out;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int n = 0; n < OUT_DIM; n++) begin
            w_full[n] = r_w[ADDR_W'(n * IN_DIM) + ADDR_W'(w_idx_sel)] * in_data;
            w_prod[n] = ACC_W'(w_full[n]);
        end
    end

    // Sum is one bit wider than the accumulator so adding the bias cannot wrap.
    always_comb begin
        for (int n = 0; n < OUT_DIM; n++) begin
            w_sum[n] = SUM_W'(r_acc[n] >>> FRAC_BITS) + SUM_W'(r_b[n]);
            if (RELU_EN != 0 && w_sum[n][SUM_W-1])
                w_res[n] = '0;
            else if (!(&w_sum[n][SUM_W-1:DATA_W-1]) && (|w_sum[n][SUM_W-1:DATA_W-1]))
                w_res[n] = w_sum[n][SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                             : {1'b0, {(DATA_W-1){1'b1}}};
            else
                w_res[n] = w_sum[n][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_oidx <= '0;
            for (int n = 0; n < OUT_DIM; n++) begin
                r_acc[n] <= '0;
                r_res[n] <= '0;
                r_b[n]   <= '0;
            end
            for (int k = 0; k < OUT_DIM * IN_DIM; k++) r_w[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx <= IDX_W'(1);
                        for (int n = 0; n < OUT_DIM; n++) r_acc[n] <= w_prod[n];
                    end
                    if (cfg_we && !cfg_sel && (int'(cfg_addr) < OUT_DIM * IN_DIM))
                        r_w[cfg_addr] <= cfg_wdata;
                    if (cfg_we && cfg_sel && (int'(cfg_addr) < OUT_DIM))
                        r_b[cfg_addr[OIDX_W-1:0]] <= cfg_wdata;
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_idx <= w_last_beat ? '0 : r_idx + IDX_W'(1);
                        for (int n = 0; n < OUT_DIM; n++) r_acc[n] <= r_acc[n] + w_prod[n];
                    end
                end
                S_FINAL: begin
                    r_oidx <= '0;
                    for (int n = 0; n < OUT_DIM; n++) r_res[n] <= w_res[n];
                end
                S_OUTPUT: begin
                    if (out_ready) r_oidx <= w_last_out ? '0 : r_oidx + OIDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: three instances (plain, ReLU, FRAC_BITS=2) share one
// stimulus stream and are checked against a software model through scoreboard queues.
module tb_dense_layer_seq;
    logic clk = 1'b0;
    logic rst, cfg_we, cfg_sel, in_valid, out_ready;
    logic [2:0] cfg_addr;
    logic signed [15:0] cfg_wdata, in_data;
    logic in_ready_a, out_valid_a, out_last_a, busy_a;
    logic in_ready_r, out_valid_r, out_last_r, busy_r;
    logic in_ready_f, out_valid_f, out_last_f, busy_f;
    logic signed [15:0] out_data_a, out_data_r, out_data_f;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_r[$];
    logic [15:0] exp_f[$];
    logic signed [15:0] m_w[8];
    logic signed [15:0] m_b[2];
    logic signed [15:0] wv[8];
    logic signed [15:0] bv[2];
    logic signed [15:0] xv[4];

    always #5 clk = ~clk;

    dense_layer_seq #(.DATA_W(16), .IN_DIM(4), .OUT_DIM(2), .FRAC_BITS(0), .RELU_EN(0)) u_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_last(out_last_a), .busy(busy_a));
    dense_layer_seq #(.DATA_W(16), .IN_DIM(4), .OUT_DIM(2), .FRAC_BITS(0), .RELU_EN(1)) u_r (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .out_last(out_last_r), .busy(busy_r));
    dense_layer_seq #(.DATA_W(16), .IN_DIM(4), .OUT_DIM(2), .FRAC_BITS(2), .RELU_EN(0)) u_f (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready_f), .in_data(in_data),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
        .out_last(out_last_f), .busy(busy_f));

    function automatic logic [15:0] model(input longint acc, input longint b,
                                          input int frac, input bit relu);
        longint r;
        r = (acc >>> frac) + b;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) m_w[k] = '0;
        for (int n = 0; n < 2; n++) m_b[n] = '0;
        exp_a.delete(); exp_r.delete(); exp_f.delete();
    endtask

    task automatic cfg_write(input logic sel, input logic [2:0] addr, input logic signed [15:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        if (!sel) m_w[addr] = data;
        else      m_b[addr[0]] = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_cfg();
        for (int k = 0; k < 8; k++) cfg_write(1'b0, 3'(k), wv[k]);
        for (int n = 0; n < 2; n++) cfg_write(1'b1, 3'(n), bv[n]);
    endtask

    // Pushes expected results, then streams xv; returns at the negedge after the last accept.
    task automatic send_vector(input bit gaps, input bit drop_cfg);
        int i = 0;
        int cyc = 0;
        int budget = 100;
        longint acc;
        for (int n = 0; n < 2; n++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) acc += longint'(m_w[n*4+k]) * longint'(xv[k]);
            exp_a.push_back(model(acc, longint'(m_b[n]), 0, 1'b0));
            exp_r.push_back(model(acc, longint'(m_b[n]), 0, 1'b1));
            exp_f.push_back(model(acc, longint'(m_b[n]), 2, 1'b0));
        end
        while (i < 4 && budget > 0) begin
            @(negedge clk);
            budget--;
            cfg_we = 1'b0;
            if (gaps && cyc % 2 == 1) begin
                in_valid = 1'b0;
                if (drop_cfg && i > 0) begin
                    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_wdata = 16'sd100;
                end
            end else begin
                in_valid = 1'b1;
                in_data = xv[i];
                if (in_ready_a) i++;
            end
            cyc++;
        end
        checks++;
        if (i != 4) begin
            failures++;
            $display("FAIL send_timeout accepted=%0d required=4", i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic collect(input int stall_cycles);
        int got = 0;
        int stall = stall_cycles;
        int budget = 100;
        bit have_held = 0;
        logic [15:0] held = '0;
        logic [15:0] e;
        while (got < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
            out_ready = 1'b0;
            if (out_valid_a) begin
                checks++;
                if (in_ready_a !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_in_output got=%b required=0", in_ready_a);
                end
                if (stall > 0) begin
                    stall--;
                    if (have_held) begin
                        checks++;
                        if (out_data_a !== held || out_last_a !== 1'b0) begin
                            failures++;
                            $display("FAIL stall_stable got=%0d/%b required=%0d/0",
                                     $signed(out_data_a), out_last_a, $signed(held));
                        end
                    end
                    held = out_data_a;
                    have_held = 1;
                end else begin
                    out_ready = 1'b1;
                    checks++;
                    if (exp_a.size() == 0 || exp_r.size() == 0 || exp_f.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output got=%0d required=none", $signed(out_data_a));
                    end else begin
                        e = exp_a.pop_front();
                        if (out_data_a !== e) begin
                            failures++;
                            $display("FAIL data_plain[%0d] got=%0d required=%0d", got, $signed(out_data_a), $signed(e));
                        end
                        checks++;
                        e = exp_r.pop_front();
                        if (out_data_r !== e || out_valid_r !== 1'b1) begin
                            failures++;
                            $display("FAIL data_relu[%0d] got=%0d required=%0d", got, $signed(out_data_r), $signed(e));
                        end
                        checks++;
                        e = exp_f.pop_front();
                        if (out_data_f !== e || out_valid_f !== 1'b1) begin
                            failures++;
                            $display("FAIL data_frac[%0d] got=%0d required=%0d", got, $signed(out_data_f), $signed(e));
                        end
                    end
                    checks++;
                    if (out_last_a !== (got == 1) || out_last_r !== (got == 1) || out_last_f !== (got == 1)) begin
                        failures++;
                        $display("FAIL out_last[%0d] got=%b required=%b", got, out_last_a, (got == 1));
                    end
                    got++;
                end
            end
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL collect_timeout got=%0d required=2", got);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL idle_after valid=%b busy=%b ready=%b required=0/0/1", out_valid_a, busy_a, in_ready_a);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0 || out_valid_a !== 1'b0 ||
            out_data_a !== 16'd0 || out_last_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ready=%b busy=%b valid=%b data=%0d last=%b required=1/0/0/0/0",
                     in_ready_a, busy_a, out_valid_a, $signed(out_data_a), out_last_a);
        end
        xv = '{16'sd5, 16'sd5, 16'sd5, 16'sd5};
        send_vector(1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_basic();
        do_reset();
        wv = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd1, 16'sd0, 16'sd0, 16'sd1};
        bv = '{16'sd10, -16'sd5};
        load_cfg();
        checks++;
        if (model(10, 10, 0, 1'b0) !== 16'd20 || model(0, -5, 0, 1'b0) !== 16'hFFFB) begin
            failures++;
            $display("FAIL basic_model got=%0d required=20", model(10, 10, 0, 1'b0));
        end
        xv = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        send_vector(1'b0, 1'b0);
        checks++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b1 || in_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL latency_final valid=%b busy=%b ready=%b required=0/1/0", out_valid_a, busy_a, in_ready_a);
        end
        @(negedge clk);
        checks++;
        if (out_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL latency_output valid=%b required=1", out_valid_a);
        end
        collect(0);
    endtask

    task automatic test_relu_sat();
        do_reset();
        wv = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, -16'sd1, -16'sd1, -16'sd1, -16'sd1};
        bv = '{16'sd0, 16'sd0};
        load_cfg();
        xv = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        send_vector(1'b0, 1'b0);
        collect(0);
        xv = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        send_vector(1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_frac();
        do_reset();
        wv = '{-16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd7, 16'sd0, 16'sd0, 16'sd0};
        bv = '{16'sd0, 16'sd0};
        load_cfg();
        xv = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        send_vector(1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_backpressure();
        do_reset();
        wv = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd1, 16'sd0, 16'sd0, 16'sd1};
        bv = '{16'sd10, -16'sd5};
        load_cfg();
        xv = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        send_vector(1'b1, 1'b1);
        collect(3);
    endtask

    task automatic test_back_to_back();
        cfg_write(1'b1, 3'd0, 16'sd100);
        xv = '{16'sd2, -16'sd1, 16'sd3, 16'sd0};
        send_vector(1'b0, 1'b0);
        collect(1);
        xv = '{-16'sd3, 16'sd4, 16'sd0, 16'sd7};
        send_vector(1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        wv = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd1, 16'sd0, 16'sd0, 16'sd1};
        bv = '{16'sd10, -16'sd5};
        load_cfg();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 16'sd9;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) m_w[k] = '0;
        for (int n = 0; n < 2; n++) m_b[n] = '0;
        checks++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state ready=%b busy=%b required=1/0", in_ready_a, busy_a);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid_a !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_leak cycle=%0d valid=%b required=0", k, out_valid_a);
            end
        end
        wv = '{16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd0, 16'sd1, 16'sd0, 16'sd0};
        bv = '{16'sd1, 16'sd1};
        load_cfg();
        xv = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        send_vector(1'b0, 1'b0);
        collect(0);
        checks++;
        if (exp_a.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d required=0", exp_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu_sat();
        test_frac();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
